mac_arbiter: RTL and testbench

MAC_ARBITER -- requirements
Module: mac_arbiter

---
 rtl/mac_arbiter.sv | 140 ++++++++++++++
 tb/tb_mac_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_arbiter.sv
// mac_arbiter: shares one pipelined MAC between two requesters.
//
// Operands from the granted requester go straight through to the MAC with no
// added latency. A TagDepth-entry tag FIFO records which requester issued each
// outstanding operation, so that in-order MAC results reach the right owner.
//
// Build option: define MAC_ARBITER_FIXED_PRIO_EN to make requester 0 win every
// tie. By default ties are broken round-robin.
//
// Ports:
//   clk_i, reset_ni         clock, asynchronous active-low reset
//   req_valid_i/req_ready_o per-requester operand handshake (2 bits)
//   req_a_i, req_b_i        operands, {req1, req0}, DataWidth bits each
//   rsp_valid_o/rsp_ready_i per-requester result handshake (2 bits)
//   rsp_c_o                 48-bit result, shared by both requesters
//   mac_valid_o/mac_ready_i operand handshake toward the MAC
//   mac_a_o, mac_b_o        operands toward the MAC
//   mac_valid_i/mac_ready_o result handshake from the MAC
//   mac_c_i                 48-bit MAC result
module mac_arbiter #(
  parameter int unsigned DataWidth = 18,
  parameter int unsigned TagDepth  = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic [1:0]             req_valid_i,
  input  logic [2*DataWidth-1:0] req_a_i,
  input  logic [2*DataWidth-1:0] req_b_i,
  output logic [1:0]             req_ready_o,
  output logic [1:0]             rsp_valid_o,
  output logic [47:0]            rsp_c_o,
  input  logic [1:0]             rsp_ready_i,
  output logic                   mac_valid_o,
  output logic [DataWidth-1:0]   mac_a_o,
  output logic [DataWidth-1:0]   mac_b_o,
  input  logic                   mac_ready_i,
  input  logic                   mac_valid_i,
  input  logic [47:0]            mac_c_i,
  output logic                   mac_ready_o
);

  localparam int unsigned PtrW = (TagDepth > 1) ? $clog2(TagDepth) : 1;
  localparam int unsigned CntW = $clog2(TagDepth + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(TagDepth);

  logic [TagDepth-1:0] tag_q;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                lock_q, lock_d;
  logic                lock_id_q, lock_id_d;
`ifndef MAC_ARBITER_FIXED_PRIO_EN
  logic                last_q, last_d;
`endif

  logic full, nonempty, gnt, head, issue, pop;

  assign full     = (count_q == CntFull);
  assign nonempty = (count_q != '0);
  assign head     = tag_q[rd_ptr_q];

  // A stalled offer keeps its requester while that requester stays valid, so
  // a late-arriving rival cannot swap operands under a pending handshake.
  always_comb begin
    gnt = req_valid_i[1];
    if (req_valid_i == 2'b11) begin
`ifdef MAC_ARBITER_FIXED_PRIO_EN
      gnt = 1'b0;
`else
      gnt = ~last_q;
`endif
    end
    if (lock_q && req_valid_i[lock_id_q]) begin
      gnt = lock_id_q;
    end
  end

  // Outputs are gated with reset_ni so they drop asynchronously in reset.
  always_comb begin
    mac_valid_o = reset_ni && (|req_valid_i) && !full;
    req_ready_o = '0;
    req_ready_o[gnt] = reset_ni && mac_ready_i && !full;
    mac_a_o = gnt ? req_a_i[2*DataWidth-1:DataWidth] : req_a_i[DataWidth-1:0];
    mac_b_o = gnt ? req_b_i[2*DataWidth-1:DataWidth] : req_b_i[DataWidth-1:0];
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_valid_o[head] = reset_ni && nonempty && mac_valid_i;
    mac_ready_o = reset_ni && nonempty && rsp_ready_i[head];
  end

  assign rsp_c_o = mac_c_i;

  assign issue = mac_valid_o && mac_ready_i;
  assign pop   = mac_valid_i && mac_ready_o;

  always_comb begin
    wr_ptr_d  = issue ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (issue && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !issue) begin
      count_d = count_q - CntW'(1);
    end
    lock_d    = mac_valid_o && !mac_ready_i;
    lock_id_d = gnt;
`ifndef MAC_ARBITER_FIXED_PRIO_EN
    last_d    = issue ? gnt : last_q;
`endif
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tag_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
`ifndef MAC_ARBITER_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      if (issue) begin
        tag_q[wr_ptr_q] <= gnt;
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`ifndef MAC_ARBITER_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter (DataWidth=18, TagDepth=4). Expected grant
// orders follow the MAC_ARBITER_FIXED_PRIO_EN build option.
module tb_mac_arbiter;

  localparam int unsigned DW = 18;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic [1:0]    req_valid_i;
  logic [2*DW-1:0] req_a_i, req_b_i;
  logic [1:0]    req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [47:0]   rsp_c_o, mac_c_i;
  logic          mac_valid_o, mac_ready_i, mac_valid_i, mac_ready_o;
  logic [DW-1:0] mac_a_o, mac_b_o;

  int checks   = 0;
  int failures = 0;

  mac_arbiter #(.DataWidth(DW), .TagDepth(4)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_c_o(rsp_c_o), .rsp_ready_i(rsp_ready_i),
    .mac_valid_o(mac_valid_o), .mac_a_o(mac_a_o), .mac_b_o(mac_b_o),
    .mac_ready_i(mac_ready_i),
    .mac_valid_i(mac_valid_i), .mac_c_i(mac_c_i), .mac_ready_o(mac_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ops(input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                     input logic [DW-1:0] a1, input logic [DW-1:0] b1);
    req_a_i = {a1, a0};
    req_b_i = {b1, b0};
  endtask

  logic [1:0] exp_g;

  initial begin
    reset_ni    = 1'b0;
    req_valid_i = 2'b11;
    ops(18'd10, 18'd11, 18'd20, 18'd21);
    rsp_ready_i = 2'b11;
    mac_ready_i = 1'b1;
    mac_valid_i = 1'b1;
    mac_c_i     = 48'd0;
    #3;
    chk("rst_mac_valid", mac_valid_o, 1'b0);
    chk("rst_req_ready", req_ready_o, 2'b00);
    chk("rst_rsp_valid", rsp_valid_o, 2'b00);
    chk("rst_mac_ready", mac_ready_o, 1'b0);
    tick();
    tick();
    reset_ni    = 1'b1;
    mac_valid_i = 1'b0;
    #1;

    // Both valid after reset: 4 issues, then full.
    for (int k = 0; k < 4; k++) begin
`ifdef MAC_ARBITER_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk("rr_req_ready", req_ready_o, exp_g);
      chk("rr_mac_a", mac_a_o, exp_g[1] ? 18'd20 : 18'd10);
      chk("rr_mac_b", mac_b_o, exp_g[1] ? 18'd21 : 18'd11);
      tick();
    end
    chk("full_mac_valid", mac_valid_o, 1'b0);
    chk("full_req_ready", req_ready_o, 2'b00);
    req_valid_i = 2'b00;
    mac_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mac_c_i = 48'(100 + k);
      #1;
`ifdef MAC_ARBITER_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk("rr_rsp_valid", rsp_valid_o, exp_g);
      chk("rr_mac_ready", mac_ready_o, 1'b1);
      chk("rr_rsp_c", rsp_c_o, 48'(100 + k));
      tick();
    end

    // Single requester 0: 3*5 comes back as 15.
    mac_valid_i = 1'b0;
    req_valid_i = 2'b01;
    ops(18'd3, 18'd5, 18'd7, 18'd9);
    #1;
    chk("r0_mac_valid", mac_valid_o, 1'b1);
    chk("r0_mac_a", mac_a_o, 18'd3);
    chk("r0_mac_b", mac_b_o, 18'd5);
    chk("r0_req_ready", req_ready_o, 2'b01);
    tick();
    req_valid_i = 2'b00;
    mac_valid_i = 1'b1;
    mac_c_i     = 48'd15;
    rsp_ready_i = 2'b01;
    #1;
    chk("r0_rsp_valid", rsp_valid_o, 2'b01);
    chk("r0_rsp_c", rsp_c_o, 48'd15);
    chk("r0_mac_ready", mac_ready_o, 1'b1);
    tick();
    chk("empty_rsp_valid", rsp_valid_o, 2'b00);
    chk("empty_mac_ready", mac_ready_o, 1'b0);

    // Fill with no results, then pop while full: no same-cycle issue.
    mac_valid_i = 1'b0;
    req_valid_i = 2'b10;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("fill_req_ready", req_ready_o, 2'b10);
      tick();
    end
    chk("fill_full_ready", req_ready_o, 2'b00);
    chk("fill_full_valid", mac_valid_o, 1'b0);
    mac_valid_i = 1'b1;
    rsp_ready_i = 2'b10;
    #1;
    chk("popfull_rsp_valid", rsp_valid_o, 2'b10);
    chk("popfull_mac_ready", mac_ready_o, 1'b1);
    chk("popfull_no_bypass", mac_valid_o, 1'b0);
    tick();
    mac_valid_i = 1'b0;
    #1;
    chk("after_pop_valid", mac_valid_o, 1'b1);
    chk("after_pop_ready", req_ready_o, 2'b10);
    tick();
    chk("refull_valid", mac_valid_o, 1'b0);
    req_valid_i = 2'b00;
    mac_valid_i = 1'b1;
    rsp_ready_i = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("drain1_rsp_valid", rsp_valid_o, 2'b10);
      tick();
    end
    chk("drain1_empty", rsp_valid_o, 2'b00);

    // Push+pop at count=2 keeps count and tag order.
    mac_valid_i = 1'b0;
    req_valid_i = 2'b01;
    tick();
    req_valid_i = 2'b10;
    tick();
    req_valid_i = 2'b01;
    mac_valid_i = 1'b1;
    #1;
    chk("pp_rsp_valid", rsp_valid_o, 2'b01);
    chk("pp_req_ready", req_ready_o, 2'b01);
    tick();
    req_valid_i = 2'b10;
    mac_valid_i = 1'b0;
    tick();
    tick();
    chk("pp_full", mac_valid_o, 1'b0);
    req_valid_i = 2'b00;
    mac_valid_i = 1'b1;
    #1;
    chk("pp_head0", rsp_valid_o, 2'b10);
    tick();
    rsp_ready_i = 2'b10;
    #1;
    chk("bp_rsp_valid", rsp_valid_o, 2'b01);
    chk("bp_mac_ready", mac_ready_o, 1'b0);
    tick();
    chk("bp_hold_rsp_valid", rsp_valid_o, 2'b01);
    chk("bp_hold_mac_ready", mac_ready_o, 1'b0);
    rsp_ready_i = 2'b11;
    #1;
    chk("bp_release", mac_ready_o, 1'b1);
    tick();
    chk("pp_head2", rsp_valid_o, 2'b10);
    tick();
    chk("pp_head3", rsp_valid_o, 2'b10);
    tick();
    chk("pp_empty", rsp_valid_o, 2'b00);

    // Stalled grant is held when the other requester arrives.
    mac_valid_i = 1'b0;
    mac_ready_i = 1'b0;
    req_valid_i = 2'b10;
    ops(18'h22, 18'h1, 18'h33, 18'h2);
    #1;
    chk("hold_valid", mac_valid_o, 1'b1);
    chk("hold_a", mac_a_o, 18'h33);
    chk("hold_ready", req_ready_o, 2'b00);
    tick();
    req_valid_i = 2'b11;
    #1;
    chk("hold_a_both", mac_a_o, 18'h33);
    tick();
    chk("hold_a_both2", mac_a_o, 18'h33);
    mac_ready_i = 1'b1;
    #1;
    chk("hold_issue_ready", req_ready_o, 2'b10);
    tick();
    req_valid_i = 2'b00;
    mac_valid_i = 1'b1;
    #1;
    chk("hold_rsp_valid", rsp_valid_o, 2'b10);
    tick();

    // Asynchronous reset with three outstanding operations.
    mac_valid_i = 1'b0;
    req_valid_i = 2'b01;
    tick();
    tick();
    tick();
    req_valid_i = 2'b11;
    mac_valid_i = 1'b1;
    #1;
    chk("pre_rst_rsp_valid", rsp_valid_o, 2'b01);
    chk("pre_rst_mac_valid", mac_valid_o, 1'b1);
    #1;
    reset_ni = 1'b0;
    #1;
    chk("arst_mac_valid", mac_valid_o, 1'b0);
    chk("arst_req_ready", req_ready_o, 2'b00);
    chk("arst_rsp_valid", rsp_valid_o, 2'b00);
    chk("arst_mac_ready", mac_ready_o, 1'b0);
    tick();
    reset_ni = 1'b1;
    #1;
    chk("post_rst_rsp_valid", rsp_valid_o, 2'b00);
    chk("post_rst_mac_ready", mac_ready_o, 1'b0);
    mac_valid_i = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
`ifdef MAC_ARBITER_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk("post_rst_grant", req_ready_o, exp_g);
      chk("post_rst_a", mac_a_o, exp_g[1] ? 18'h33 : 18'h22);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
